bls_result_arbiter: RTL and testbench

Collects priced results from NUM_ENG parallel Black-Scholes engines and serialises them onto one valid/ready output stream toward the host/result memory. A round-robin arbiter grants at most one engine per cycle into a small result FIFO. Each result is tagged with its option index and source engine. Engines stall until acknowledged. Sits between the engine array and the result writer, alongside the engine dispatch controller.

---
 rtl/bls_pkg.sv | 9 +
 rtl/bls_result_arbiter_if.sv | 24 ++
 rtl/bls_result_fifo.sv | 39 +++
 rtl/bls_result_arbiter.sv | 75 +++++++
 tb/tb_bls_result_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bls_pkg.sv
// bls_pkg: shared Black-Scholes array defaults and engine-index width helper
package bls_pkg;
  localparam int BLS_NUM_ENG = 4;
  localparam int BLS_PRICE_W = 32;
  localparam int BLS_TAG_W = 16;
  function automatic int eng_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bls_result_arbiter_if.sv
// bls_result_arbiter_if: engine result ports and host-side result stream
interface bls_result_arbiter_if #(
  parameter int NUM_ENG = bls_pkg::BLS_NUM_ENG,
  parameter int PRICE_W = bls_pkg::BLS_PRICE_W,
  parameter int TAG_W = bls_pkg::BLS_TAG_W
);
  logic [NUM_ENG-1:0] eng_valid;
  logic [NUM_ENG*PRICE_W-1:0] eng_price;
  logic [NUM_ENG*TAG_W-1:0] eng_tag;
  logic [NUM_ENG-1:0] eng_ack;
  logic out_valid;
  logic out_ready;
  logic [PRICE_W-1:0] out_price;
  logic [TAG_W-1:0] out_tag;
  logic [bls_pkg::eng_w(NUM_ENG)-1:0] out_eng;
  modport master (
    output eng_valid, eng_price, eng_tag, out_ready,
    input eng_ack, out_valid, out_price, out_tag, out_eng
  );
  modport slave (
    input eng_valid, eng_price, eng_tag, out_ready,
    output eng_ack, out_valid, out_price, out_tag, out_eng
  );
endinterface

// File: rtl/bls_result_fifo.sv
// bls_result_fifo: synchronous FIFO with flush, fill count and zeroed head when empty
module bls_result_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input logic clock,
  input logic reset,
  input logic clear,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] fill
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign push_ok = push && fill != (AW+1)'(DEPTH);
  assign pop_ok = pop && fill != '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  // storage is never reset; entries are only visible while fill covers them
  always_ff @(posedge clock)
    if (push_ok && !clear) mem[wr_ptr] <= din;
  assign dout = (fill == '0) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/bls_result_arbiter.sv
// bls_result_arbiter: round-robin collection of engine results into one tagged output stream
module bls_result_arbiter
  import bls_pkg::*;
#(
  parameter int NUM_ENG = BLS_NUM_ENG,
  parameter int PRICE_W = BLS_PRICE_W,
  parameter int TAG_W = BLS_TAG_W,
  parameter int FIFO_DEPTH = 8
) (
  input logic clock,
  input logic reset,
  input logic clear,
  bls_result_arbiter_if.slave bus,
  output logic [31:0] result_count,
  output logic busy
);
  localparam int ENG_W = eng_w(NUM_ENG);
  localparam int W = ENG_W + TAG_W + PRICE_W;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  logic [ENG_W-1:0] last_grant, gnt, hi, lo;
  logic hi_hit, push, pop;
  logic [TAG_W-1:0] tag;
  logic [PRICE_W-1:0] price;
  logic [FW-1:0] fill;
  logic [W-1:0] head;
  // lowest valid index above last_grant wins, else wrap to the lowest valid index
  always_comb begin
    hi = '0;
    lo = '0;
    hi_hit = 1'b0;
    tag = '0;
    price = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--)
      if (bus.eng_valid[i]) begin
        lo = ENG_W'(i);
        if (i > int'(last_grant)) begin
          hi = ENG_W'(i);
          hi_hit = 1'b1;
        end
      end
    gnt = hi_hit ? hi : lo;
    for (int i = 0; i < NUM_ENG; i++)
      if (ENG_W'(i) == gnt) begin
        tag = bus.eng_tag[i*TAG_W +: TAG_W];
        price = bus.eng_price[i*PRICE_W +: PRICE_W];
      end
  end
  assign push = fill != FW'(FIFO_DEPTH) && |bus.eng_valid && !clear;
  assign pop = bus.out_valid && bus.out_ready;
  assign bus.eng_ack = push ? NUM_ENG'(1) << gnt : '0;
  assign bus.out_valid = fill != '0;
  assign {bus.out_eng, bus.out_tag, bus.out_price} = head;
  assign busy = bus.out_valid || |bus.eng_valid;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last_grant <= ENG_W'(NUM_ENG - 1);
      result_count <= '0;
    end else if (clear) begin
      last_grant <= ENG_W'(NUM_ENG - 1);
      result_count <= '0;
    end else begin
      if (push) last_grant <= gnt;
      if (pop) result_count <= result_count + 32'd1;
    end
  bls_result_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) fifo (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .push(push),
    .pop(pop),
    .din({gnt, tag, price}),
    .dout(head),
    .fill(fill)
  );
endmodule

// File: tb/tb_bls_result_arbiter.sv
// tb_bls_result_arbiter: directed and random stimulus against a queue-based reference model
module tb_bls_result_arbiter;
  import bls_pkg::*;
  localparam int N = 4, PW = 32, TW = 16, D = 8, EW = eng_w(N);
  typedef struct packed {
    logic [EW-1:0] eng;
    logic [TW-1:0] tag;
    logic [PW-1:0] price;
  } res_t;
  logic clock = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [31:0] result_count;
  logic busy;
  bls_result_arbiter_if #(.NUM_ENG(N), .PRICE_W(PW), .TAG_W(TW)) bus();
  bls_result_arbiter #(.NUM_ENG(N), .PRICE_W(PW), .TAG_W(TW), .FIFO_DEPTH(D)) dut (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .bus(bus.slave),
    .result_count(result_count),
    .busy(busy)
  );
  always #5 clock = ~clock;
  int checks = 0, passed = 0;
  res_t q[$];
  int last = N - 1, gnt;
  logic [31:0] cnt = '0;
  logic [N-1:0] ev = '0;
  logic [TW-1:0] et[N];
  logic [PW-1:0] ep[N];
  logic ready = 1'b0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // one clock: drive, predict and compare before the edge, then advance the model
  task automatic cycle(input logic clr);
    res_t head;
    clear = clr;
    bus.out_ready = ready;
    bus.eng_valid = ev;
    for (int i = 0; i < N; i++) begin
      bus.eng_tag[i*TW +: TW] = et[i];
      bus.eng_price[i*PW +: PW] = ep[i];
    end
    #1;
    gnt = -1;
    if (!clr && q.size() < D)
      for (int k = 1; k <= N; k++)
        if (gnt < 0 && ev[(last + k) % N]) gnt = (last + k) % N;
    head = (q.size() != 0) ? q[0] : '0;
    check("eng_ack", bus.eng_ack, (gnt < 0) ? 64'd0 : 64'd1 << gnt);
    check("out_valid", bus.out_valid, q.size() != 0);
    check("out_price", bus.out_price, head.price);
    check("out_tag", bus.out_tag, head.tag);
    check("out_eng", bus.out_eng, head.eng);
    check("result_count", result_count, cnt);
    check("busy", busy, q.size() != 0 || ev != '0);
    if (clr) begin
      q.delete();
      last = N - 1;
      cnt = '0;
    end else begin
      if (q.size() != 0 && ready) begin
        void'(q.pop_front());
        cnt++;
      end
      if (gnt >= 0) begin
        q.push_back(res_t'{eng: EW'(gnt), tag: et[gnt], price: ep[gnt]});
        last = gnt;
      end
    end
    @(negedge clock);
  endtask
  // acked or idle engines load a fresh result with probability pct; others rarely withdraw
  task automatic engines(input int pct);
    for (int i = 0; i < N; i++)
      if (gnt == i || !ev[i]) begin
        ev[i] = $urandom_range(0, 99) < pct;
        et[i] = TW'($urandom);
        ep[i] = $urandom;
      end else if ($urandom_range(0, 19) == 0) ev[i] = 1'b0;
  endtask
  task automatic drain();
    ev = '0;
    ready = 1'b1;
    repeat (D + 2) cycle(1'b0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      et[i] = '0;
      ep[i] = '0;
    end
    bus.eng_valid = '0;
    bus.eng_price = '0;
    bus.eng_tag = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_eng_ack", bus.eng_ack, '0);
    check("rst_count", result_count, '0);
    check("rst_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b0);
    ev = 4'b0100;
    et[2] = 16'h0005;
    ep[2] = 32'h0001_0000;
    cycle(1'b0);
    ev = '0;
    cycle(1'b0);
    ready = 1'b1;
    cycle(1'b0);
    ready = 1'b0;
    cycle(1'b0);
    ev = '1;
    ready = 1'b1;
    repeat (12) begin
      cycle(1'b0);
      engines(100);
    end
    drain();
    ready = 1'b0;
    ev = 4'b0010;
    repeat (10) begin
      cycle(1'b0);
      if (gnt == 1) begin
        et[1] = TW'($urandom);
        ep[1] = $urandom;
      end
    end
    ready = 1'b1;
    cycle(1'b0);
    ready = 1'b0;
    repeat (3) cycle(1'b0);
    drain();
    ready = 1'b0;
    ev = '1;
    repeat (5) begin
      cycle(1'b0);
      engines(100);
    end
    cycle(1'b1);
    cycle(1'b0);
    drain();
    ready = 1'b0;
    ev = 4'b0001;
    cycle(1'b0);
    ev = '0;
    dut.result_count = 32'hFFFF_FFFF;
    cnt = 32'hFFFF_FFFF;
    ready = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    repeat (2000) begin
      ready = $urandom_range(0, 3) != 0;
      cycle($urandom_range(0, 63) == 0);
      engines(50);
    end
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
